// File: rtl/maq_mh_if.sv
// maq_mh_if: control inputs and time outputs of the minutes/hours stage.
//   master: drives enable, incrementaminuto, ajuste, btn_min, btn_hora; reads the time digits,
//           pm, incrementadia and modo_ajuste.
//   slave : the timekeeping stage itself (opposite directions).
interface maq_mh_if;
    logic       maqmh_enable;
    logic       maqmh_incrementaminuto;
    logic       maqmh_ajuste;
    logic       maqmh_btn_min;
    logic       maqmh_btn_hora;
    logic [3:0] maqmh_min_lsd;
    logic [2:0] maqmh_min_msd;
    logic [3:0] maqmh_hora_lsd;
    logic [1:0] maqmh_hora_msd;
    logic       maqmh_pm;
    logic       maqmh_incrementadia;
    logic       maqmh_modo_ajuste;
    modport master (
        output maqmh_enable, maqmh_incrementaminuto, maqmh_ajuste, maqmh_btn_min, maqmh_btn_hora,
        input  maqmh_min_lsd, maqmh_min_msd, maqmh_hora_lsd, maqmh_hora_msd,
               maqmh_pm, maqmh_incrementadia, maqmh_modo_ajuste
    );
    modport slave (
        input  maqmh_enable, maqmh_incrementaminuto, maqmh_ajuste, maqmh_btn_min, maqmh_btn_hora,
        output maqmh_min_lsd, maqmh_min_msd, maqmh_hora_lsd, maqmh_hora_msd,
               maqmh_pm, maqmh_incrementadia, maqmh_modo_ajuste
    );
endinterface

// File: rtl/maq_mh.sv
// maq_mh: BCD minutes/hours counter fed by the seconds-stage minute carry, with button time-set mode.
//   maqmh_clock : system clock, rising edge
//   maqmh_reset : synchronous active-high reset
//   maqmh_bus   : maq_mh_if.slave -- enable, minute carry, ajuste, buttons in; digits, pm,
//                 day-carry pulse and set-mode flag out
module maq_mh #(
    parameter bit FORMATO_24H = 1'b1
) (
    input  logic    maqmh_clock,
    input  logic    maqmh_reset,
    maq_mh_if.slave maqmh_bus
);
    typedef enum logic {CONTANDO = 1'b0, AJUSTE = 1'b1} estado_t;
    estado_t    estado;
    logic [3:0] min_lsd, hora_lsd, min_lsd_nx, hora_lsd_nx;
    logic [2:0] min_msd, min_msd_nx;
    logic [1:0] hora_msd, hora_msd_nx;
    logic       pm, incrementadia;
    logic       prev_inc, prev_btn_min, prev_btn_hora;
    logic       ev_inc, ev_btn_min, ev_btn_hora;
    logic       min_wrap, hora_wrap, hora_onze, min_step, hora_step, dia_step;
    always_comb begin
        // previous registers are held high across reset, so a level already high is not an edge
        ev_inc      = maqmh_bus.maqmh_enable & maqmh_bus.maqmh_incrementaminuto & ~prev_inc;
        ev_btn_min  = maqmh_bus.maqmh_enable & maqmh_bus.maqmh_btn_min & ~prev_btn_min;
        ev_btn_hora = maqmh_bus.maqmh_enable & maqmh_bus.maqmh_btn_hora & ~prev_btn_hora;
        min_wrap    = (min_msd == 3'd5) && (min_lsd == 4'd9);
        min_lsd_nx  = (min_lsd == 4'd9) ? 4'd0 : min_lsd + 4'd1;
        min_msd_nx  = min_wrap ? 3'd0 : (min_lsd == 4'd9) ? min_msd + 3'd1 : min_msd;
        hora_onze   = (hora_msd == 2'd1) && (hora_lsd == 4'd1);
        // 24h wraps 23 -> 00, 12h wraps 12 -> 01
        hora_wrap   = FORMATO_24H ? (hora_msd == 2'd2) && (hora_lsd == 4'd3)
                                  : (hora_msd == 2'd1) && (hora_lsd == 4'd2);
        hora_lsd_nx = hora_wrap ? (FORMATO_24H ? 4'd0 : 4'd1) : (hora_lsd == 4'd9) ? 4'd0 : hora_lsd + 4'd1;
        hora_msd_nx = hora_wrap ? 2'd0 : (hora_lsd == 4'd9) ? hora_msd + 2'd1 : hora_msd;
        min_step    = (estado == CONTANDO) ? ev_inc : ev_btn_min;
        hora_step   = (estado == CONTANDO) ? ev_inc & min_wrap : ev_btn_hora;
        // end of day: 23:59 in 24h, 11:59 PM in 12h
        dia_step    = (estado == CONTANDO) & ev_inc & min_wrap & (FORMATO_24H ? hora_wrap : hora_onze & pm);
    end
    always_ff @(posedge maqmh_clock) begin
        if (maqmh_reset) begin
            estado        <= CONTANDO;
            min_lsd       <= 4'd0;
            min_msd       <= 3'd0;
            hora_lsd      <= FORMATO_24H ? 4'd0 : 4'd2;
            hora_msd      <= FORMATO_24H ? 2'd0 : 2'd1;
            pm            <= 1'b0;
            incrementadia <= 1'b0;
            prev_inc      <= 1'b1;
            prev_btn_min  <= 1'b1;
            prev_btn_hora <= 1'b1;
        end else begin
            estado        <= maqmh_bus.maqmh_ajuste ? AJUSTE : CONTANDO;
            incrementadia <= dia_step;
            prev_inc      <= maqmh_bus.maqmh_incrementaminuto;
            prev_btn_min  <= maqmh_bus.maqmh_btn_min;
            prev_btn_hora <= maqmh_bus.maqmh_btn_hora;
            if (min_step) begin
                min_lsd <= min_lsd_nx;
                min_msd <= min_msd_nx;
            end
            if (hora_step) begin
                hora_lsd <= hora_lsd_nx;
                hora_msd <= hora_msd_nx;
                if (!FORMATO_24H && hora_onze) pm <= ~pm;
            end
        end
    end
    assign maqmh_bus.maqmh_min_lsd       = min_lsd;
    assign maqmh_bus.maqmh_min_msd       = min_msd;
    assign maqmh_bus.maqmh_hora_lsd      = hora_lsd;
    assign maqmh_bus.maqmh_hora_msd      = hora_msd;
    assign maqmh_bus.maqmh_pm            = FORMATO_24H ? 1'b0 : pm;
    assign maqmh_bus.maqmh_incrementadia = incrementadia;
    assign maqmh_bus.maqmh_modo_ajuste   = (estado == AJUSTE);
endmodule

// File: tb/tb_maq_mh.sv
// tb_maq_mh: scoreboard bench driving a 24h and a 12h instance with identical stimulus.
module tb_maq_mh;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1, inc = 1'b0, aj = 1'b0, bm = 1'b0, bh = 1'b0;
    int   total = 0, bad = 0;
    always #5 clk = ~clk;
    maq_mh_if b24 ();
    maq_mh_if b12 ();
    assign b24.maqmh_enable = en;
    assign b24.maqmh_incrementaminuto = inc;
    assign b24.maqmh_ajuste = aj;
    assign b24.maqmh_btn_min = bm;
    assign b24.maqmh_btn_hora = bh;
    assign b12.maqmh_enable = en;
    assign b12.maqmh_incrementaminuto = inc;
    assign b12.maqmh_ajuste = aj;
    assign b12.maqmh_btn_min = bm;
    assign b12.maqmh_btn_hora = bh;
    maq_mh #(.FORMATO_24H(1'b1)) dut24 (.maqmh_clock(clk), .maqmh_reset(rst), .maqmh_bus(b24.slave));
    maq_mh #(.FORMATO_24H(1'b0)) dut12 (.maqmh_clock(clk), .maqmh_reset(rst), .maqmh_bus(b12.slave));
    // reference: minutes 0..59 and a 24-hour count 0..23; the 12h view is derived at compare time
    typedef struct {int m; int h; bit day; bit mode;} exp_t;
    exp_t q[$];
    int   m_min = 0, m_h = 0;
    bit   m_day = 0, m_mode = 0, p_inc = 1, p_bm = 1, p_bh = 1;
    task automatic model();
        bit ei, ebm, ebh;
        exp_t e;
        if (rst) begin
            m_min = 0; m_h = 0; m_day = 0; m_mode = 0; p_inc = 1; p_bm = 1; p_bh = 1;
        end else begin
            ei = en && inc && !p_inc;
            ebm = en && bm && !p_bm;
            ebh = en && bh && !p_bh;
            m_day = 0;
            if (!m_mode && ei) begin
                m_min = m_min + 1;
                if (m_min == 60) begin
                    m_min = 0;
                    m_h = m_h + 1;
                    if (m_h == 24) begin m_h = 0; m_day = 1; end
                end
            end
            if (m_mode) begin
                if (ebm) m_min = (m_min + 1) % 60;
                if (ebh) m_h = (m_h + 1) % 24;
            end
            m_mode = aj; p_inc = inc; p_bm = bm; p_bh = bh;
        end
        e.m = m_min; e.h = m_h; e.day = m_day; e.mode = m_mode;
        q.push_back(e);
    endtask
    task automatic step(input bit r, e, i, a, b_m, b_h);
        rst = r; en = e; inc = i; aj = a; bm = b_m; bh = b_h;
        @(posedge clk);
        model();
        #2;
    endtask
    task automatic set_time(input int h, input int mm, input bit stay);
        step(0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 30 && m_h != h; k++) begin
            step(0, 1, 0, 1, 0, 1);
            step(0, 1, 0, 1, 0, 0);
        end
        for (int k = 0; k < 70 && m_min != mm; k++) begin
            step(0, 1, 0, 1, 1, 0);
            step(0, 1, 0, 1, 0, 0);
        end
        if (!stay) step(0, 1, 0, 0, 0, 0);
    endtask
    initial begin : monitor
        exp_t e;
        int   h12;
        logic [15:0] exp24, exp12, got24, got12;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                h12 = (e.h % 12 == 0) ? 12 : e.h % 12;
                exp24 = {2'(e.h / 10), 4'(e.h % 10), 3'(e.m / 10), 4'(e.m % 10), 1'b0, e.day, e.mode};
                exp12 = {2'(h12 / 10), 4'(h12 % 10), 3'(e.m / 10), 4'(e.m % 10), e.h >= 12, e.day, e.mode};
                got24 = {b24.maqmh_hora_msd, b24.maqmh_hora_lsd, b24.maqmh_min_msd, b24.maqmh_min_lsd,
                         b24.maqmh_pm, b24.maqmh_incrementadia, b24.maqmh_modo_ajuste};
                got12 = {b12.maqmh_hora_msd, b12.maqmh_hora_lsd, b12.maqmh_min_msd, b12.maqmh_min_lsd,
                         b12.maqmh_pm, b12.maqmh_incrementadia, b12.maqmh_modo_ajuste};
                total++;
                if (got24 !== exp24) begin
                    bad++;
                    $display("FAIL dut24 t=%0t got=%h exp=%h (hh_mm_pm_day_mode)", $time, got24, exp24);
                end
                total++;
                if (got12 !== exp12) begin
                    bad++;
                    $display("FAIL dut12 t=%0t got=%h exp=%h (hh_mm_pm_day_mode)", $time, got12, exp12);
                end
            end
        end
    end
    initial begin : stim
        bit r, e, i, a, b_m, b_h;
        #2;
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        set_time(0, 5, 0);
        repeat (50) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        set_time(23, 59, 0);
        step(0, 1, 1, 0, 0, 0);
        repeat (2) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        set_time(11, 59, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        set_time(12, 30, 1);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 1, 0, 0);
        set_time(10, 59, 1);
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 1, 1);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        r = 0; e = 1; i = 0; a = 0; b_m = 0; b_h = 0;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) i = ~i;
            if ($urandom_range(0, 39) == 0) a = ~a;
            if ($urandom_range(0, 2) == 0) b_m = ~b_m;
            if ($urandom_range(0, 3) == 0) b_h = ~b_h;
            step(r, e, i, a, b_m, b_h);
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
